// File: rtl/script_sequencer.sv
`default_nettype none
// ============================================================================
// script_sequencer: fetch/decode/dispatch stage of the kitchen script processor
// Rev 1.0
// ============================================================================
module script_sequencer #(
   parameter int JUMP_HOLD = 3,
   parameter int ACT_TMO   = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] rom_addr,
   input  logic [7:0] rom_data,
   output logic       jump_en,
   output logic [1:0] jump_func,
   output logic [2:0] jump_sign,
   output logic [7:0] jump_num,
   output logic [7:0] cur_pc,
   input  logic [7:0] jump_next_pc,
   input  logic       jump_ready,
   output logic       act_en,
   output logic [4:0] act_func,
   output logic [7:0] act_num,
   input  logic       act_done,
   output logic       busy,
   output logic       halted,
   output logic       err
);

   typedef enum logic [2:0] {
      S_IDLE, S_F0, S_F1, S_DEC, S_ACT, S_JMP, S_WAIT, S_HALT
   } state_e;

   localparam logic [7:0] HOLD_LAST = 8'(JUMP_HOLD - 1);
   localparam logic [7:0] TMO_LAST  = 8'(ACT_TMO - 1);
   localparam logic [2:0] OP_ACT    = 3'b001;
   localparam logic [2:0] OP_JMP    = 3'b010;
   localparam logic [2:0] OP_WAIT   = 3'b011;
   localparam logic [2:0] OP_END    = 3'b111;

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] num_q, num_d;
   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;
   logic [7:0] pc_inc;

   assign pc_inc = pc_q + 8'd2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= 8'd0;
         ir_q    <= 8'd0;
         num_q   <= 8'd0;
         cnt_q   <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         num_q   <= num_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      num_d    = num_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rom_addr = pc_q;
      jump_en  = 1'b0;
      act_en   = 1'b0;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d    = 8'd0;
               err_d   = 1'b0;
               state_d = S_F0;
            end
         end
         S_F0: state_d = S_F1;
         S_F1: begin
            ir_d     = rom_data;
            rom_addr = pc_q + 8'd1;
            state_d  = S_DEC;
         end
         S_DEC: begin
            // byte0 is already in ir_q; byte1 arrives on rom_data this cycle
            num_d = rom_data;
            cnt_d = 8'd0;
            case (ir_q[7:5])
               OP_ACT:  state_d = S_ACT;
               OP_JMP:  state_d = S_JMP;
               OP_WAIT: begin
                  if (rom_data == 8'd0) begin
                     pc_d    = pc_inc;
                     state_d = S_F0;
                  end else begin
                     state_d = S_WAIT;
                  end
               end
               OP_END:  state_d = S_HALT;
               default: begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end
            endcase
         end
         S_ACT: begin
            act_en = (cnt_q == 8'd0);
            if (act_done) begin
               pc_d    = pc_inc;
               state_d = S_F0;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_JMP: begin
            jump_en = 1'b1;
            if (cnt_q == HOLD_LAST) begin
               if (!jump_ready) begin
                  err_d   = 1'b1;
                  state_d = S_HALT;
               end else begin
                  pc_d    = (jump_next_pc == pc_q) ? pc_inc : jump_next_pc;
                  state_d = S_F0;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_WAIT: begin
            if (cnt_q == num_q - 8'd1) begin
               pc_d    = pc_inc;
               state_d = S_F0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign jump_func = ir_q[4:3];
   assign jump_sign = ir_q[2:0];
   assign jump_num  = num_q;
   assign act_func  = ir_q[4:0];
   assign act_num   = num_q;
   assign cur_pc    = pc_q;
   assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
   assign halted    = (state_q == S_HALT);
   assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_script_sequencer.sv
`default_nettype none
// tb_script_sequencer: randomized programs + directed cases, scored against an
// instruction-level timing model of the sequencer.
module tb_script_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] rom_addr;
   logic [7:0] rom_data = 8'd0;
   logic       jump_en;
   logic [1:0] jump_func;
   logic [2:0] jump_sign;
   logic [7:0] jump_num;
   logic [7:0] cur_pc;
   logic [7:0] jump_next_pc = 8'd0;
   logic       jump_ready = 1'b0;
   logic       act_en;
   logic [4:0] act_func;
   logic [7:0] act_num;
   logic       act_done = 1'b0;
   logic       busy;
   logic       halted;
   logic       err;

   script_sequencer #(.JUMP_HOLD(3), .ACT_TMO(255)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_addr(rom_addr), .rom_data(rom_data),
      .jump_en(jump_en), .jump_func(jump_func), .jump_sign(jump_sign),
      .jump_num(jump_num), .cur_pc(cur_pc),
      .jump_next_pc(jump_next_pc), .jump_ready(jump_ready),
      .act_en(act_en), .act_func(act_func), .act_num(act_num),
      .act_done(act_done), .busy(busy), .halted(halted), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;   // 0 action dispatch, 1 jump dispatch, 2 halt
      int t;      // cycles after the first fetch cycle
      int pc;
      int f;
      int num;
      int err;
   } ev_t;

   ev_t        exp_q[$];
   int         jq[$];     // jump stub responses: bit 8 ready, [7:0] next pc
   int         aq[$];     // action stub delays (cycles after act_en)
   int         dj[$];     // directed jump responses for the model
   int         da[$];     // directed action delays for the model
   logic [7:0] rom [256];
   int         lastpc;
   int         cyc = 0;
   int         t0 = 0;
   int         ncmp = 0;
   int         nfail = 0;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rom_data <= rom[rom_addr];

   // jump unit stub
   bit js_prev = 1'b0;
   int jr;
   always @(negedge clk) begin
      if (jump_en && !js_prev) begin
         jr = (jq.size() > 0) ? jq.pop_front() : 0;
         jump_ready   = jr[8];
         jump_next_pc = jr[7:0];
      end else if (!jump_en) begin
         jump_ready = 1'b0;
      end
      js_prev = jump_en;
   end

   // action unit stub
   int rem = 0;
   int ad;
   always @(negedge clk) begin
      if (!busy) begin
         rem = 0;
         act_done = 1'b0;
      end else if (act_en) begin
         ad = (aq.size() > 0) ? aq.pop_front() : 0;
         rem = ad;
         act_done = (ad == 0);
      end else if (rem > 0) begin
         rem--;
         act_done = (rem == 0);
      end else begin
         act_done = 1'b0;
      end
   end

   task automatic chk(input string nm, input int got, input int want);
      ncmp++;
      if (got != want) begin
         nfail++;
         $display("FAIL %s: got %0d, want %0d", nm, got, want);
      end
   endtask

   task automatic check_ev(input int kind, input int f, input int num);
      ev_t e;
      int  rel;
      bit  ok;
      rel = cyc - t0;
      ncmp++;
      if (exp_q.size() == 0) begin
         nfail++;
         $display("FAIL unexpected_event: got kind=%0d t=%0d pc=%02h, want no event", kind, rel, cur_pc);
      end else begin
         e  = exp_q.pop_front();
         ok = (e.kind == kind) && (e.t == rel) && (e.pc == int'(cur_pc));
         if (kind == 2) ok = ok && (e.err == int'(err));
         else           ok = ok && (e.f == f) && (e.num == num);
         if (!ok) begin
            nfail++;
            $display("FAIL event: got kind=%0d t=%0d pc=%02h f=%02h num=%02h err=%0d, want kind=%0d t=%0d pc=%02h f=%02h num=%02h err=%0d",
                     kind, rel, cur_pc, f, num, err, e.kind, e.t, e.pc, e.f, e.num, e.err);
         end
      end
   endtask

   // monitor
   bit mj_prev = 1'b0;
   bit mh_prev = 1'b0;
   int jw = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         mj_prev = 1'b0;
         mh_prev = 1'b0;
         jw = 0;
      end else begin
         if (act_en) check_ev(0, int'(act_func), int'(act_num));
         if (jump_en && !mj_prev) check_ev(1, int'({jump_func, jump_sign}), int'(jump_num));
         if (jump_en) jw++;
         else if (mj_prev) begin
            chk("jump_hold_cycles", jw, 3);
            jw = 0;
         end
         if (halted && !mh_prev) check_ev(2, 0, 0);
         mj_prev = jump_en;
         mh_prev = halted;
      end
   end

   function automatic void push_ev(int k, int t, int pc, int f, int num, int e);
      ev_t ev;
      ev.kind = k; ev.t = t; ev.pc = pc; ev.f = f; ev.num = num; ev.err = e;
      exp_q.push_back(ev);
   endfunction

   // Instruction-level model: walks the ROM, decides stub responses and
   // predicts the time of each dispatch/halt.
   task automatic model();
      logic [7:0] pc, b0, b1;
      int  t, d, r, steps;
      bit  done;
      pc = 8'd0; t = 0; steps = 0; done = 1'b0;
      while (!done && steps < 300) begin
         steps++;
         b0 = rom[pc];
         b1 = rom[8'(pc + 8'd1)];
         case (b0[7:5])
            3'b001: begin
               d = (da.size() > 0) ? da.pop_front() : int'($urandom_range(0, 6));
               aq.push_back(d);
               push_ev(0, t + 3, int'(pc), int'(b0[4:0]), int'(b1), 0);
               if (d >= 255) begin
                  push_ev(2, t + 3 + 255, int'(pc), 0, 0, 1);
                  done = 1'b1;
               end else begin
                  pc = pc + 8'd2;
                  t  = t + 4 + d;
               end
            end
            3'b010: begin
               if (dj.size() > 0) r = dj.pop_front();
               else if ($urandom_range(0, 19) == 0) r = int'($urandom_range(0, 255));
               else if ($urandom_range(0, 1) == 1 && int'(pc) < lastpc)
                  r = 256 | (int'(pc) + 2 * int'($urandom_range(1, (lastpc - int'(pc)) / 2)));
               else r = 256 | int'(pc);
               jq.push_back(r);
               push_ev(1, t + 3, int'(pc), int'(b0[4:0]), int'(b1), 0);
               if (r[8] == 1'b0) begin
                  push_ev(2, t + 6, int'(pc), 0, 0, 1);
                  done = 1'b1;
               end else begin
                  pc = (r[7:0] == pc) ? pc + 8'd2 : r[7:0];
                  t  = t + 6;
               end
            end
            3'b011: begin
               t  = t + 3 + int'(b1);
               pc = pc + 8'd2;
            end
            3'b111: begin
               push_ev(2, t + 3, int'(pc), 0, 0, 0);
               done = 1'b1;
            end
            default: begin
               push_ev(2, t + 3, int'(pc), 0, 0, 1);
               done = 1'b1;
            end
         endcase
      end
   endtask

   task automatic clr_all();
      exp_q.delete(); jq.delete(); aq.delete(); dj.delete(); da.delete();
   endtask

   task automatic clr_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clr_all();
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      t0 = cyc;
      start = 1'b0;
   endtask

   task automatic scenario(input int max_cyc);
      int n;
      model();
      pulse_start();
      chk("start_err_clear", int'(err), 0);
      chk("start_rom_addr", int'(rom_addr), 0);
      n = 0;
      while (!halted && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (!halted) begin
         ncmp++;
         nfail++;
         $display("FAIL halt_timeout: halted=0 after %0d cycles, want 1", n);
         do_reset();
      end
      repeat (2) @(negedge clk);
      chk("events_drained", exp_q.size(), 0);
      clr_all();
   endtask

   task automatic rand_program();
      int L;
      int p;
      logic [2:0] op;
      clr_rom();
      L = int'($urandom_range(3, 10));
      lastpc = 2 * (L - 1);
      for (int i = 0; i < L - 1; i++) begin
         p = int'($urandom_range(0, 99));
         if (p < 40) begin
            rom[2*i] = {3'b001, 5'($urandom)};
            rom[2*i+1] = 8'($urandom);
         end else if (p < 65) begin
            rom[2*i] = {3'b010, 2'($urandom_range(0, 1)), 3'($urandom_range(0, 3))};
            rom[2*i+1] = 8'($urandom);
         end else if (p < 90) begin
            rom[2*i] = {3'b011, 5'($urandom)};
            rom[2*i+1] = 8'($urandom_range(0, 5));
         end else begin
            op = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(4, 6));
            rom[2*i] = {op, 5'($urandom)};
            rom[2*i+1] = 8'($urandom);
         end
      end
      rom[lastpc] = {3'b111, 5'($urandom)};
      rom[lastpc+1] = 8'($urandom);
   endtask

   initial begin
      int n;
      clr_rom();
      lastpc = 0;
      repeat (3) @(negedge clk);
      chk("rst_rom_addr", int'(rom_addr), 0);
      chk("rst_cur_pc", int'(cur_pc), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_halted", int'(halted), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_jump_en", int'(jump_en), 0);
      chk("rst_act_en", int'(act_en), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // action then end, act_done 4 cycles after act_en
      clr_rom();
      rom[0] = 8'h20; rom[1] = 8'h05; rom[2] = 8'hE0; rom[3] = 8'h00;
      da.push_back(4);
      scenario(200);
      chk("end_halted", int'(halted), 1);
      chk("end_pc", int'(cur_pc), 2);

      // jumpif at pc=4: taken to 10, fall-through, then not ready
      clr_rom();
      rom[0] = 8'h60; rom[2] = 8'h60; rom[4] = 8'h40; rom[5] = 8'h03;
      rom[6] = 8'hE0; rom[10] = 8'hE0;
      dj.push_back(256 | 10);
      scenario(200);
      dj.push_back(256 | 4);
      scenario(200);
      rom[4] = 8'h49;
      dj.push_back(10);
      scenario(200);

      // illegal op; the following start must clear err
      clr_rom();
      rom[0] = 8'h80;
      scenario(200);
      chk("illegal_err", int'(err), 1);

      // wait 7 at 0xFE wraps to 0x00
      clr_rom();
      rom[0] = 8'h40; rom[1] = 8'h05; rom[2] = 8'hE0;
      rom[8'hFE] = 8'h67; rom[8'hFF] = 8'h07;
      dj.push_back(256 | 8'hFE);
      dj.push_back(256 | 0);
      scenario(200);

      // act_done on the last allowed cycle, then never
      clr_rom();
      rom[0] = 8'h21; rom[1] = 8'h01; rom[2] = 8'hE0;
      da.push_back(254);
      scenario(600);
      chk("act_late_ok_err", int'(err), 0);
      da.push_back(9999);
      scenario(600);
      chk("act_timeout_err", int'(err), 1);

      // reset asserted in the middle of a jump hold
      clr_rom();
      rom[0] = 8'h60; rom[2] = 8'h60; rom[4] = 8'h40; rom[5] = 8'h03; rom[6] = 8'hE0;
      dj.push_back(256 | 4);
      model();
      pulse_start();
      n = 0;
      while (!jump_en && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("jmp_seen", int'(jump_en), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstmid_jump_en", int'(jump_en), 0);
      chk("rstmid_cur_pc", int'(cur_pc), 0);
      chk("rstmid_busy", int'(busy), 0);
      chk("rstmid_halted", int'(halted), 0);
      clr_all();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int s = 0; s < 25; s++) begin
         rand_program();
         scenario(2000);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
